fft_stage_sequencer: RTL and testbench
======================================

// Module: fft_stage_sequencer
// PURPOSE
// - Sequences the 8-lane FFT/IFFT/NTT datapath across all stages of one transform.
// - Per stage: issues vector reads to the ping-pong coefficient banks, then drives the
//   datapath mode controls (point, pre_sel, inverse, last-stage flags, sum triggers).
// - Issues the matching delayed writes once the pipeline has drained.
// - Sits between the host/top controller (start/done handshake) and the datapath + bank memories.
// PARAMETERS
// - ADDR_W    9   vector-address width (one address = 8 lanes)
// - STAGE_W   4   stage-counter width
// - PIPE_LAT  6   cycles from rd_en to result at datapath output, incl. output register; >=1
// PORTS
// - clk                 in   1        clock
// - rst_n               in   1        reset, asynchronous, active-high
// - start               in   1        begin transform; sampled only in IDLE
// - abort               in   1        synchronous cancel
// - cfg_inverse         in   1        0=forward, 1=inverse; latched at start
// - cfg_point           in   3        datapath point code; latched at start
// - cfg_point_2_mode    in   1        datapath 2-point mode; latched at start
// - cfg_stages          in   STAGE_W  stage count; 0 treated as 1
// - cfg_words           in   ADDR_W   vectors per stage; 0 treated as 1
// - busy                out  1        high from the cycle after start until done
// - done                out  1        1-cycle pulse at completion
// - rd_en               out  1        bank read strobe
// - rd_addr             out  ADDR_W   read vector address
// - rd_bank             out  1        bank being read
// - wr_en               out  1        bank write strobe
// - wr_addr             out  ADDR_W   write vector address
// - wr_bank             out  1        bank being written
// - point               out  3        datapath point code
// - point_2_mode        out  1        datapath 2-point mode
// - inverse             out  1        datapath inverse control
// - pre_sel             out  3        datapath pre-select
// - fft_last_stage      out  1        high for the whole final stage of a forward run
// - ifft_last_stage     out  1        high for the whole final stage of an inverse run
// - sum_trigger         out  1        accumulation trigger pulse
// - sum_trigger_delay8  out  1        sum_trigger delayed 8 cycles
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; all counters and delay pipes cleared.
// - FSM states: IDLE -> RUN -> DRAIN -> (RUN of next stage | DONE) -> IDLE.
// - IDLE, start=1:
//   - latch cfg; stage_cnt=0; word_cnt=0; enter RUN next cycle.
//   - start while busy is ignored.
// - RUN (cfg_words cycles):
//   - rd_en=1; rd_addr=word_cnt, incrementing 0..words-1.
//   - When word_cnt reaches words-1: enter DRAIN.
// - DRAIN (PIPE_LAT cycles):
//   - rd_en=0.
//   - When the drain count is exhausted and stage_cnt<stages-1: stage_cnt++, word_cnt=0, enter RUN.
//   - Otherwise enter DONE.
// - DONE: done=1 for one cycle; busy=0 in the same cycle; return to IDLE.
// - Write side:
//   - wr_en and wr_addr are rd_en and rd_addr delayed exactly PIPE_LAT cycles (shift pipe).
//   - All writes of a stage land within that stage's DRAIN window.
//   - No read of stage s+1 occurs before the last write of stage s.
// - Banks:
//   - rd_bank=stage_cnt[0]; wr_bank=~stage_cnt[0].
//   - Result resides in bank stages[0].
// - pre_sel = min(stage_cnt,7).
// - point, point_2_mode and inverse hold their latched values while busy; 0 in IDLE.
// - Last-stage flags:
//   - fft_last_stage = busy & final stage & ~inverse.
//   - ifft_last_stage = busy & final stage & inverse.
//   - Both cover RUN and DRAIN of the final stage.
// - sum_trigger: 1-cycle pulse on the first RUN cycle of the final stage, inverse runs only.
// - sum_trigger_delay8: 8-stage shift of sum_trigger.
// - Timing: start sampled at edge 0 -> first rd_en at cycle 1 -> done at cycle 1+stages*(words+PIPE_LAT).
// - abort (any state): next cycle IDLE; rd_en, wr_en and both delay pipes cleared; no done pulse.
//   abort wins over a simultaneous start.
// - Reset mid-run: identical to abort, but asynchronous.
// CONFIGURATION
// - FFT_SEQ_PERF_EN defined:
//   - extra output perf_cycles (out, 16).
//   - Cleared at start; +1 each busy cycle, saturating at 16'hFFFF.
//   - Holds its value after done until the next start.
// - FFT_SEQ_PERF_EN undefined: port and counter are absent.
// STRUCTURE
// - Package fft_seq_pkg: state enum (IDLE/RUN/DRAIN/DONE), SUM_DLY=8, PRE_SEL_MAX=7.
// - Sub-module fft_seq_delay_line (param WIDTH, DEPTH; async clear + sync flush).
//   - Instantiated for {rd_en,rd_addr} -> write side and for the sum_trigger delay.
// TESTING
// - Reset: rst_n=1 mid-RUN -> all outputs 0 immediately; after release, IDLE and busy=0.
// - stages=3, words=4, PIPE_LAT=6, forward, start@0:
//   - rd_en in cycles 1-4, 11-14, 21-24.
//   - wr_en in cycles 7-10, 17-20, 27-30.
//   - rd_bank=0,1,0.
//   - fft_last_stage cycles 21-30; done@31.
// - stages=2, words=1, inverse:
//   - ifft_last_stage cycles 8-14; sum_trigger@8; sum_trigger_delay8@16.
//   - fft_last_stage never set.
// - cfg_stages=0, cfg_words=0 -> one stage of one word; done@1+1+PIPE_LAT=8.
// - abort at cycle 12 of the 3x4 run:
//   - busy=0 @13; no wr_en after cycle 12; no done.
//   - start@14 re-runs cleanly from bank 0.
// - start pulsed while busy -> ignored, schedule unchanged.
// - FFT_SEQ_PERF_EN: the 3x4 run -> perf_cycles=30, held after done.

Source files
------------

// File: rtl/fft_seq_pkg.sv
// ---------------------------------------------------------------------------
// fft_seq_pkg
// Shared types and constants for the FFT/IFFT/NTT stage sequencer.
//   seq_state_e    : sequencer FSM states (IDLE/RUN/DRAIN/DONE)
//   SUM_DLY        : depth of the sum_trigger delay line
//   PRE_SEL_MAX    : largest datapath pre-select code
//   clamp_pre_sel  : stage index -> pre-select code, saturating at PRE_SEL_MAX
// ---------------------------------------------------------------------------
package fft_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int          SUM_DLY     = 8;
  localparam int unsigned PRE_SEL_MAX = 7;

  // Stages past the last pre-select code reuse the final code.
  function automatic logic [2:0] clamp_pre_sel(input int unsigned stage);
    return (stage > PRE_SEL_MAX) ? 3'(PRE_SEL_MAX) : 3'(stage);
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer_if
// Bundles the host handshake/config, bank read/write strobes and datapath
// mode controls of the stage sequencer.
//   master : host/controller side (drives start/abort/cfg_*, observes the rest)
//   slave  : sequencer side
// Optional: FFT_SEQ_PERF_EN adds perf_cycles[15:0] (sequencer -> host).
// ---------------------------------------------------------------------------
interface fft_stage_sequencer_if #(
  parameter int ADDR_W  = 9,
  parameter int STAGE_W = 4
);

  // Host -> sequencer
  logic               start;
  logic               abort;
  logic               cfg_inverse;
  logic [2:0]         cfg_point;
  logic               cfg_point_2_mode;
  logic [STAGE_W-1:0] cfg_stages;
  logic [ADDR_W-1:0]  cfg_words;

  // Sequencer -> host / banks / datapath
  logic               busy;
  logic               done;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_bank;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic               wr_bank;
  logic [2:0]         point;
  logic               point_2_mode;
  logic               inverse;
  logic [2:0]         pre_sel;
  logic               fft_last_stage;
  logic               ifft_last_stage;
  logic               sum_trigger;
  logic               sum_trigger_delay8;

`ifdef FFT_SEQ_PERF_EN
  logic [15:0]        perf_cycles;

  modport master (
    output start, abort, cfg_inverse, cfg_point, cfg_point_2_mode, cfg_stages, cfg_words,
    input  busy, done, rd_en, rd_addr, rd_bank, wr_en, wr_addr, wr_bank,
           point, point_2_mode, inverse, pre_sel, fft_last_stage, ifft_last_stage,
           sum_trigger, sum_trigger_delay8, perf_cycles
  );

  modport slave (
    input  start, abort, cfg_inverse, cfg_point, cfg_point_2_mode, cfg_stages, cfg_words,
    output busy, done, rd_en, rd_addr, rd_bank, wr_en, wr_addr, wr_bank,
           point, point_2_mode, inverse, pre_sel, fft_last_stage, ifft_last_stage,
           sum_trigger, sum_trigger_delay8, perf_cycles
  );
`else
  modport master (
    output start, abort, cfg_inverse, cfg_point, cfg_point_2_mode, cfg_stages, cfg_words,
    input  busy, done, rd_en, rd_addr, rd_bank, wr_en, wr_addr, wr_bank,
           point, point_2_mode, inverse, pre_sel, fft_last_stage, ifft_last_stage,
           sum_trigger, sum_trigger_delay8
  );

  modport slave (
    input  start, abort, cfg_inverse, cfg_point, cfg_point_2_mode, cfg_stages, cfg_words,
    output busy, done, rd_en, rd_addr, rd_bank, wr_en, wr_addr, wr_bank,
           point, point_2_mode, inverse, pre_sel, fft_last_stage, ifft_last_stage,
           sum_trigger, sum_trigger_delay8
  );
`endif

endinterface

// File: rtl/fft_seq_delay_line.sv
// ---------------------------------------------------------------------------
// fft_seq_delay_line
// Fixed-latency shift pipe: o_data is i_data delayed exactly DEPTH cycles.
// Ports:
//   clk      in  clock
//   rst_n    in  asynchronous reset, active-HIGH despite the name
//   i_flush  in  synchronous clear of every stage (wins over shifting)
//   i_data   in  WIDTH-bit input
//   o_data   out WIDTH-bit output, DEPTH cycles late
// ---------------------------------------------------------------------------
module fft_seq_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  // NOTE: this register array is reset and flushed on purpose: a stale strobe
  // leaking out after reset/abort would issue a spurious bank write, so it is
  // built from flops rather than treated as an unreset RAM.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the value its
      // neighbour held before the edge, so loop order does not matter.
      r_pipe[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer
// Sequences the 8-lane FFT/IFFT/NTT datapath through every stage of one
// transform: per stage it streams vector reads from one ping-pong bank, lets
// the pipeline drain, and replays the reads PIPE_LAT cycles later as writes
// into the other bank. It also drives the datapath mode controls.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous reset, active-HIGH despite the name
//   bus    slave modport of fft_stage_sequencer_if (handshake, config,
//               bank strobes/addresses, datapath controls)
// Optional: define FFT_SEQ_PERF_EN to add bus.perf_cycles, a saturating count
//   of busy cycles cleared at start and held after completion.
// ---------------------------------------------------------------------------
module fft_stage_sequencer
  import fft_seq_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int STAGE_W  = 4,
  parameter int PIPE_LAT = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_stage_sequencer_if.slave  bus
);

  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  seq_state_e         r_state, w_state_nxt;
  logic               r_inverse, r_point_2_mode;
  logic [2:0]         r_point;
  logic [STAGE_W-1:0] r_stage_cnt, r_last_stage;
  logic [ADDR_W-1:0]  r_word_cnt, r_last_word;
  logic [DRAIN_W-1:0] r_drain_cnt;

  logic               w_start_acc, w_busy, w_rd_en, w_final;
  logic               w_word_done, w_drain_done;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [ADDR_W:0]    w_wr_pipe;
  logic               w_sum_trigger, w_sum_delayed;

  // Abort beats a simultaneous start.
  assign w_start_acc  = (r_state == IDLE) && bus.start && !bus.abort;
  assign w_busy       = (r_state == RUN) || (r_state == DRAIN);
  assign w_rd_en      = (r_state == RUN);
  assign w_final      = (r_stage_cnt == r_last_stage);
  assign w_word_done  = (r_word_cnt == r_last_word);
  assign w_drain_done = (r_drain_cnt == DRAIN_W'(PIPE_LAT - 1));
  assign w_rd_addr    = w_rd_en ? r_word_cnt : '0;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt; no latch.
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_acc) w_state_nxt = RUN;
      RUN:     if (w_word_done) w_state_nxt = DRAIN;
      DRAIN:   if (w_drain_done) w_state_nxt = w_final ? DONE : RUN;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (bus.abort) w_state_nxt = IDLE;
  end

  // ------------- counters and latched configuration -------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_inverse      <= 1'b0;
      r_point        <= '0;
      r_point_2_mode <= 1'b0;
      r_last_stage   <= '0;
      r_last_word    <= '0;
      r_stage_cnt    <= '0;
      r_word_cnt     <= '0;
      r_drain_cnt    <= '0;
    end else if (bus.abort) begin
      r_stage_cnt <= '0;
      r_word_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_inverse      <= bus.cfg_inverse;
          r_point        <= bus.cfg_point;
          r_point_2_mode <= bus.cfg_point_2_mode;
          // Store last indices; a zero count behaves like a count of one.
          r_last_stage   <= (bus.cfg_stages == '0) ? '0 : bus.cfg_stages - STAGE_W'(1);
          r_last_word    <= (bus.cfg_words == '0)  ? '0 : bus.cfg_words - ADDR_W'(1);
          r_stage_cnt    <= '0;
          r_word_cnt     <= '0;
          r_drain_cnt    <= '0;
        end
        RUN: if (w_word_done) begin
          r_word_cnt  <= '0;
          r_drain_cnt <= '0;
        end else begin
          r_word_cnt <= r_word_cnt + ADDR_W'(1);
        end
        DRAIN: if (w_drain_done) begin
          r_drain_cnt <= '0;
          if (!w_final) r_stage_cnt <= r_stage_cnt + STAGE_W'(1);
        end else begin
          r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // ------------- write side: reads replayed after the pipeline -------------
  // Read address is zeroed when not reading so wr_addr is 0 between writes.
  fft_seq_delay_line #(.WIDTH(ADDR_W + 1), .DEPTH(PIPE_LAT)) u_wr_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (bus.abort),
    .i_data  ({w_rd_en, w_rd_addr}),
    .o_data  (w_wr_pipe)
  );

  // Accumulation trigger: first read of the final stage, inverse runs only.
  assign w_sum_trigger = w_rd_en && w_final && r_inverse && (r_word_cnt == '0);

  fft_seq_delay_line #(.WIDTH(1), .DEPTH(SUM_DLY)) u_sum_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (bus.abort),
    .i_data  (w_sum_trigger),
    .o_data  (w_sum_delayed)
  );

  // ---------------- outputs ----------------
  assign bus.busy               = w_busy;
  assign bus.done               = (r_state == DONE);
  assign bus.rd_en              = w_rd_en;
  assign bus.rd_addr            = w_rd_addr;
  assign bus.wr_en              = w_wr_pipe[ADDR_W];
  assign bus.wr_addr            = w_wr_pipe[ADDR_W-1:0];
  // Writes of a stage finish inside its DRAIN, so the stage counter still
  // names the stage being written. Banks read 0 when idle.
  assign bus.rd_bank            = w_busy &&  r_stage_cnt[0];
  assign bus.wr_bank            = w_busy && !r_stage_cnt[0];
  assign bus.point              = w_busy ? r_point : '0;
  assign bus.point_2_mode       = w_busy && r_point_2_mode;
  assign bus.inverse            = w_busy && r_inverse;
  assign bus.pre_sel            = w_busy ? clamp_pre_sel(32'(r_stage_cnt)) : '0;
  assign bus.fft_last_stage     = w_busy && w_final && !r_inverse;
  assign bus.ifft_last_stage    = w_busy && w_final &&  r_inverse;
  assign bus.sum_trigger        = w_sum_trigger;
  assign bus.sum_trigger_delay8 = w_sum_delayed;

`ifdef FFT_SEQ_PERF_EN
  logic [15:0] r_perf_cycles;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                                   r_perf_cycles <= '0;
    else if (w_start_acc)                        r_perf_cycles <= '0;
    else if (w_busy && r_perf_cycles != 16'hFFFF) r_perf_cycles <= r_perf_cycles + 16'd1;
  end

  assign bus.perf_cycles = r_perf_cycles;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_stage_sequencer
// Directed bench for fft_stage_sequencer (ADDR_W=9, STAGE_W=4, PIPE_LAT=6).
// Cycle numbering: cycle 0 is the cycle in which start is held high; cycle n
// is the n-th clock period after the edge that samples it. Outputs are
// sampled on the falling edge; inputs change on the falling edge.
// Reset (rst_n) is active-high.
// ---------------------------------------------------------------------------
module tb_fft_stage_sequencer;

  localparam int ADDR_W   = 9;
  localparam int STAGE_W  = 4;
  localparam int PIPE_LAT = 6;

  logic clk = 1'b0;
  logic rst_n;

  fft_stage_sequencer_if #(.ADDR_W(ADDR_W), .STAGE_W(STAGE_W)) bus ();

  fft_stage_sequencer #(.ADDR_W(ADDR_W), .STAGE_W(STAGE_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {28'd0, bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.rd_bank,
            bus.wr_en, bus.wr_addr, bus.wr_bank, bus.point, bus.point_2_mode,
            bus.inverse, bus.pre_sel, bus.fft_last_stage, bus.ifft_last_stage,
            bus.sum_trigger, bus.sum_trigger_delay8};
  endfunction

  // One transform: configuration, optional start pokes while busy, and the
  // hand-computed milestones of its schedule (-1 = never happens).
  typedef struct {
    string              name;
    logic [STAGE_W-1:0] stages;
    logic [ADDR_W-1:0]  words;
    logic               inv;
    logic [2:0]         pt;
    logic               p2;
    int                 poke_a;
    int                 poke_b;
    int                 exp_done;
    int                 exp_xfers;
    int                 exp_lf_first;
    int                 exp_lf_last;
    int                 exp_sum;
    int                 exp_sum8;
  } vec_t;

  vec_t vecs[6];

  // Runs one transform and compares it to the record. The per-cycle model
  // places read k of a w-word stage s at cycle 1 + s*(w+PIPE_LAT) + k%w and
  // its write PIPE_LAT cycles later, in banks s[0] and ~s[0].
  task automatic run_vec(input vec_t v);
    int w, s, k;
    int rd_idx = 0, wr_idx = 0, err = 0;
    int done_cyc = -1, done_cnt = 0, busy_cnt = 0;
    int lf_first = -1, lf_last = -1, other_cnt = 0;
    int sum_first = -1, sum_cnt = 0, s8_first = -1, s8_cnt = 0;
    logic lf, other;
    w = (v.words == '0) ? 1 : int'(v.words);

    @(negedge clk);
    bus.cfg_stages       = v.stages;
    bus.cfg_words        = v.words;
    bus.cfg_inverse      = v.inv;
    bus.cfg_point        = v.pt;
    bus.cfg_point_2_mode = v.p2;
    bus.start            = 1'b1;

    for (int c = 1; c <= v.exp_done + 10; c++) begin
      @(negedge clk);
      bus.start       = (c == v.poke_a) || (c == v.poke_b);
      bus.cfg_point   = bus.start ? ~v.pt : v.pt;
      bus.cfg_inverse = bus.start ? ~v.inv : v.inv;

      lf    = v.inv ? bus.ifft_last_stage : bus.fft_last_stage;
      other = v.inv ? bus.fft_last_stage  : bus.ifft_last_stage;

      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
        if (bus.busy) err++;
      end
      if (bus.busy) begin
        busy_cnt++;
        if (bus.point !== v.pt || bus.point_2_mode !== v.p2 || bus.inverse !== v.inv) err++;
      end else if (bus.point != 3'd0 || bus.inverse || bus.point_2_mode ||
                   bus.pre_sel != 3'd0 || bus.rd_en || bus.wr_en || lf || other) begin
        err++;
      end
      if (lf) begin
        if (lf_first < 0) lf_first = c;
        lf_last = c;
      end
      if (other) other_cnt++;
      if (bus.sum_trigger) begin
        sum_cnt++;
        if (sum_first < 0) sum_first = c;
      end
      if (bus.sum_trigger_delay8) begin
        s8_cnt++;
        if (s8_first < 0) s8_first = c;
      end
      if (bus.rd_en) begin
        s = rd_idx / w;
        k = rd_idx % w;
        if (c != 1 + s * (w + PIPE_LAT) + k || int'(bus.rd_addr) != k ||
            bus.rd_bank != s[0] || bus.pre_sel != 3'((s > 7) ? 7 : s)) err++;
        rd_idx++;
      end
      if (bus.wr_en) begin
        s = wr_idx / w;
        k = wr_idx % w;
        if (c != 1 + s * (w + PIPE_LAT) + k + PIPE_LAT || int'(bus.wr_addr) != k ||
            bus.wr_bank != !s[0]) err++;
        wr_idx++;
      end
    end
    bus.start       = 1'b0;
    bus.cfg_point   = v.pt;
    bus.cfg_inverse = v.inv;

    check({v.name, ":done_cycle"},  done_cyc,  v.exp_done);
    check({v.name, ":done_pulses"}, done_cnt,  1);
    check({v.name, ":busy_cycles"}, busy_cnt,  v.exp_done - 1);
    check({v.name, ":reads"},       rd_idx,    v.exp_xfers);
    check({v.name, ":writes"},      wr_idx,    v.exp_xfers);
    check({v.name, ":last_first"},  lf_first,  v.exp_lf_first);
    check({v.name, ":last_last"},   lf_last,   v.exp_lf_last);
    check({v.name, ":wrong_last"},  other_cnt, 0);
    check({v.name, ":sum_cycle"},   sum_first, v.exp_sum);
    check({v.name, ":sum_pulses"},  sum_cnt,   (v.exp_sum < 0) ? 0 : 1);
    check({v.name, ":sum8_cycle"},  s8_first,  v.exp_sum8);
    check({v.name, ":sum8_pulses"}, s8_cnt,    (v.exp_sum8 < 0) ? 0 : 1);
    check({v.name, ":schedule"},    err,       0);
`ifdef FFT_SEQ_PERF_EN
    check({v.name, ":perf_held"},   bus.perf_cycles, v.exp_done - 1);
`endif
  endtask

  // Counts cycles with any sequencer activity over a window.
  task automatic count_activity(input int cycles, output int act);
    act = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.busy || bus.rd_en || bus.wr_en || bus.done) act++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int   act;

    //          name          stg     words   inv   pt    p2    pokes  done xfer lf_first lf_last sum sum8
    vecs[0] = '{"fwd_3x4",    4'd3,   9'd4,   1'b0, 3'd5, 1'b0, 0,  0,  31,  12,  21,  30,  -1, -1};
    vecs[1] = '{"inv_2x1",    4'd2,   9'd1,   1'b1, 3'd2, 1'b1, 0,  0,  15,   2,   8,  14,   8, 16};
    vecs[2] = '{"zero_cfg",   4'd0,   9'd0,   1'b0, 3'd7, 1'b1, 0,  0,   8,   1,   1,   7,  -1, -1};
    vecs[3] = '{"inv_1x3",    4'd1,   9'd3,   1'b1, 3'd1, 1'b0, 0,  0,  10,   3,   1,   9,   1,  9};
    vecs[4] = '{"fwd_9x2",    4'd9,   9'd2,   1'b0, 3'd4, 1'b1, 0,  0,  73,  18,  65,  72,  -1, -1};
    vecs[5] = '{"start_busy", 4'd3,   9'd4,   1'b0, 3'd6, 1'b0, 5, 31,  31,  12,  21,  30,  -1, -1};

    rst_n                = 1'b1;
    bus.start            = 1'b0;
    bus.abort            = 1'b0;
    bus.cfg_inverse      = 1'b0;
    bus.cfg_point        = 3'd0;
    bus.cfg_point_2_mode = 1'b0;
    bus.cfg_stages       = '0;
    bus.cfg_words        = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("idle_outputs", out_vec(), 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Abort at cycle 12 of the 3x4 run, then restart at cycle 14.
    @(negedge clk);
    bus.cfg_stages = 4'd3;
    bus.cfg_words  = 9'd4;
    bus.cfg_inverse = 1'b0;
    bus.start      = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 12) begin
        check("abort_pre_rd_en", bus.rd_en, 1);
        bus.abort = 1'b1;
      end
      if (c == 13) begin
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_rd_en", bus.rd_en, 0);
        check("abort_wr_en", bus.wr_en, 0);
        check("abort_done", bus.done, 0);
      end
    end
    rv = vecs[0];
    rv.name = "restart";
    run_vec(rv);

    // Abort together with start in IDLE: nothing starts.
    @(negedge clk);
    bus.cfg_stages = 4'd1;
    bus.cfg_words  = 9'd1;
    bus.start      = 1'b1;
    bus.abort      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_start_busy", bus.busy, 0);
    count_activity(12, act);
    check("abort_start_quiet", act, 0);

    // Reset asserted mid-RUN clears outputs at once and leaves IDLE.
    @(negedge clk);
    bus.cfg_stages = 4'd3;
    bus.cfg_words  = 9'd4;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", bus.busy, 1);
    rst_n = 1'b1;
    #1;
    check("reset_async_outputs", out_vec(), 0);
    @(negedge clk);
    rst_n = 1'b0;
    count_activity(12, act);
    check("post_reset_quiet", act, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
